// File: rtl/rot_coef_gen.sv
// rot_coef_gen: rotation coefficient generator for the pixel-rotation datapath.
// Latches a degree code and mode on each task pulse from the capture/rotate
// controller and produces signed Q2.(CW-2) cos/sin coefficients.
//   i_clk, i_rst_n  clock, async active-low reset
//   i_newtask       one-cycle task pulse
//   i_deg           angle code, 64 steps per turn
//   i_mode          display mode, 0 = no rotation
//   o_busy          combinational busy back to the controller
//   o_cos, o_sin    registered coefficients
//   o_mode          mode associated with the current coefficients
//   o_valid         one-cycle pulse when the coefficients update
// Build option: define ROT_COEF_LUT_EN to replace the iterative CORDIC with a
// 17-entry quarter-wave sine ROM (fixed 3-cycle latency).
module rot_coef_gen #(
    parameter int unsigned ITER = 14,
    parameter int unsigned CW   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_newtask,
    input  logic [5:0]           i_deg,
    input  logic [2:0]           i_mode,
    output logic                 o_busy,
    output logic signed [CW-1:0] o_cos,
    output logic signed [CW-1:0] o_sin,
    output logic [2:0]           o_mode,
    output logic                 o_valid
);
    // two guard bits so CORDIC overshoot above 1.0 never wraps before saturation
    localparam int unsigned IW = CW + 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic signed [IW-1:0] ONE = IW'(1) <<< (CW - 2);

    logic [1:0]           state_r, state_nx;
    logic                 busy_r;
    logic [2:0]           mode_r;
    logic [1:0]           quad_r;
    logic signed [IW-1:0] x_r, y_r;
    logic signed [IW-1:0] map_x, map_y;
    logic signed [CW-1:0] cos_r, sin_r;

`ifdef ROT_COEF_LUT_EN
    localparam int unsigned SH_L = (CW >= 16) ? CW - 16 : 0;
    localparam int unsigned SH_R = (CW >= 16) ? 0 : 16 - CW;

    // round(sin(k * 5.625 deg) * 16384), k = 0..16
    function automatic logic [14:0] sin_rom(input logic [4:0] k);
        case (k)
            5'd0:    return 15'd0;
            5'd1:    return 15'd1606;
            5'd2:    return 15'd3196;
            5'd3:    return 15'd4756;
            5'd4:    return 15'd6270;
            5'd5:    return 15'd7723;
            5'd6:    return 15'd9102;
            5'd7:    return 15'd10394;
            5'd8:    return 15'd11585;
            5'd9:    return 15'd12665;
            5'd10:   return 15'd13623;
            5'd11:   return 15'd14449;
            5'd12:   return 15'd15137;
            5'd13:   return 15'd15679;
            5'd14:   return 15'd16069;
            5'd15:   return 15'd16305;
            5'd16:   return 15'd16384;
            default: return 15'd0;
        endcase
    endfunction

    // ROM is Q2.14; rescale to the configured coefficient width
    function automatic logic signed [IW-1:0] rom_scale(input logic [14:0] v);
        return (IW'(v) <<< SH_L) >>> SH_R;
    endfunction
`else
    localparam int unsigned ZW = 18;
    // CORDIC gain compensation 0.607253 in Q2.(CW-2)
    localparam logic [63:0]          K_WIDE = (64'd39797 << (CW - 2)) >> 16;
    localparam logic signed [IW-1:0] K_INIT = IW'(K_WIDE);

    // round(atan(2^-i) * 65536 / (2*pi))
    function automatic logic signed [ZW-1:0] atan_lut(input logic [3:0] i);
        case (i)
            4'd0:    return 18'sd8192;
            4'd1:    return 18'sd4836;
            4'd2:    return 18'sd2555;
            4'd3:    return 18'sd1297;
            4'd4:    return 18'sd651;
            4'd5:    return 18'sd326;
            4'd6:    return 18'sd163;
            4'd7:    return 18'sd81;
            4'd8:    return 18'sd41;
            4'd9:    return 18'sd20;
            4'd10:   return 18'sd10;
            4'd11:   return 18'sd5;
            4'd12:   return 18'sd3;
            4'd13:   return 18'sd1;
            4'd14:   return 18'sd1;
            default: return 18'sd0;
        endcase
    endfunction

    logic signed [ZW-1:0] z_r;
    logic [3:0]           iter_r;
    logic                 iter_last;
    logic                 z_pos;
    logic signed [IW-1:0] x_sh, y_sh;
    logic signed [IW-1:0] x_nx, y_nx;
    logic signed [ZW-1:0] z_nx;
    logic [13:0]          residual;

    // residual angle within the quadrant: low 14 bits of {deg, 10'b0}
    assign residual  = {i_deg[3:0], 10'b0};
    assign iter_last = (iter_r == 4'(ITER - 1));

    // one micro-rotation
    always_comb begin
        z_pos = ~z_r[ZW-1];
        x_sh  = x_r >>> iter_r;
        y_sh  = y_r >>> iter_r;
        x_nx  = z_pos ? (x_r - y_sh) : (x_r + y_sh);
        y_nx  = z_pos ? (y_r + x_sh) : (y_r - x_sh);
        z_nx  = z_pos ? (z_r - atan_lut(iter_r)) : (z_r + atan_lut(iter_r));
    end
`endif

    function automatic logic signed [CW-1:0] sat(input logic signed [IW-1:0] v);
        if (v > ONE)
            return CW'(ONE);
        else if (v < -ONE)
            return CW'(-ONE);
        else
            return CW'(v);
    endfunction

    // controller samples busy in the same cycle it raises newtask
    assign o_busy = i_newtask | busy_r;

    // quadrant mapping of the first-quadrant result
    always_comb begin
        map_x = x_r;
        map_y = y_r;
        case (quad_r)
            2'd1:    begin map_x = -y_r; map_y = x_r;  end
            2'd2:    begin map_x = -x_r; map_y = -y_r; end
            2'd3:    begin map_x = y_r;  map_y = -x_r; end
            default: ;
        endcase
    end

    // state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state_r <= S_IDLE;
        else
            state_r <= state_nx;
    end

    // next-state logic; new tasks are only accepted in IDLE
    always_comb begin
        state_nx = state_r;
        case (state_r)
            S_IDLE: begin
                if (i_newtask) begin
`ifdef ROT_COEF_LUT_EN
                    state_nx = S_FIX;
`else
                    state_nx = (i_mode == 3'd0) ? S_DONE : S_ITER;
`endif
                end
            end
`ifndef ROT_COEF_LUT_EN
            S_ITER:  if (iter_last) state_nx = S_FIX;
`endif
            S_FIX:   state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // datapath and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_r  <= 1'b0;
            mode_r  <= 3'd0;
            quad_r  <= 2'd0;
            x_r     <= '0;
            y_r     <= '0;
            cos_r   <= CW'(ONE);
            sin_r   <= '0;
            o_cos   <= CW'(ONE);
            o_sin   <= '0;
            o_mode  <= 3'd0;
            o_valid <= 1'b0;
`ifndef ROT_COEF_LUT_EN
            z_r     <= '0;
            iter_r  <= '0;
`endif
        end else begin
            o_valid <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (i_newtask) begin
                        busy_r <= 1'b1;
                        mode_r <= i_mode;
                        quad_r <= i_deg[5:4];
`ifdef ROT_COEF_LUT_EN
                        if (i_mode == 3'd0) begin
                            x_r    <= ONE;
                            y_r    <= '0;
                            quad_r <= 2'd0;
                        end else begin
                            x_r <= rom_scale(sin_rom(5'd16 - {1'b0, i_deg[3:0]}));
                            y_r <= rom_scale(sin_rom({1'b0, i_deg[3:0]}));
                        end
`else
                        cos_r  <= CW'(ONE);
                        sin_r  <= '0;
                        x_r    <= K_INIT;
                        y_r    <= '0;
                        z_r    <= ZW'(residual);
                        iter_r <= '0;
`endif
                    end
                end
`ifndef ROT_COEF_LUT_EN
                S_ITER: begin
                    x_r    <= x_nx;
                    y_r    <= y_nx;
                    z_r    <= z_nx;
                    iter_r <= iter_r + 4'd1;
                end
`endif
                S_FIX: begin
                    cos_r <= sat(map_x);
                    sin_r <= sat(map_y);
                end
                S_DONE: begin
                    o_cos   <= cos_r;
                    o_sin   <= sin_r;
                    o_mode  <= mode_r;
                    o_valid <= 1'b1;
                    busy_r  <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/rot_coef_gen.md
Name: rot_coef_gen

Overview:
- Downstream consumer of the capture/rotate controller's task interface (newtask, deg, mode, busy).
- On each new-task pulse, latches the 6-bit degree code and 3-bit mode, and computes signed cos/sin rotation coefficients with an iterative CORDIC.
- Presents the coefficients to the pixel-rotation datapath.
- Drives busy back to the controller so it holds in its NEWTASK state until the coefficients are valid.

Parameters:
- ITER, 14, number of CORDIC iterations (valid range 8..15).
- CW, 16, coefficient width, signed Q2.(CW-2).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_newtask  in  1  one-cycle task pulse from the controller
- i_deg  in  6  angle code; angle = i_deg*5.625 deg (64 steps per turn)
- i_mode  in  3  display mode; 0 = no rotation
- o_busy  out  1  computation in progress (to controller i_busy)
- o_cos  out  CW  cos coefficient, signed Q2.14
- o_sin  out  CW  sin coefficient, signed Q2.14
- o_mode  out  3  mode latched with the current coefficients
- o_valid  out  1  one-cycle pulse when o_cos/o_sin/o_mode update

Behaviour:
- Reset values: o_cos=16384, o_sin=0, o_mode=0, o_valid=0, internal busy=0, state IDLE.
- Reset mid-computation aborts the computation and restores the reset values.
- o_busy = i_newtask | busy_r, combinational.
  - Required because the controller samples busy in the same cycle newtask is high.
- Phase: p = {i_deg,10'b0} (16 bits, full turn = 65536); quadrant q = p[15:14]; residual r = p[13:0].
- Angle wrap-around is inherent: i_deg 63 -> 0 needs no special case.
- States:
  - IDLE: on i_newtask, latch deg and mode, set busy_r=1.
    - If mode==0 -> DONE with cos=16384, sin=0.
    - Otherwise -> ITER state with x=9949 (K*2^14), y=0, z=r, i=0.
  - ITER: one micro-rotation per cycle.
    - d = (z>=0) ? +1 : -1.
    - x -= d*(y>>>i); y += d*(x>>>i); z -= d*ATAN[i].
    - ATAN[i] = round(atan(2^-i)*65536/(2*pi)), 18-bit signed internal width.
    - Arithmetic shifts; no saturation inside the loop.
    - After ITER iterations -> FIX.
  - FIX: quadrant map.
    - q=0: (x,y); q=1: (-y,x); q=2: (-x,-y); q=3: (y,-x).
    - Saturate results to +/-16384; -> DONE.
  - DONE: register outputs, pulse o_valid=1, clear busy_r; -> IDLE.
- Latency, newtask to o_valid: ITER+3 cycles for mode!=0; 2 cycles for mode==0.
- o_busy is high from the newtask cycle through the cycle before o_valid, and low in the o_valid cycle.
- i_newtask while busy_r=1 is ignored; the computation in progress completes with the originally latched values.
- Outputs hold their values between tasks.

Optional Feature:
- ROT_COEF_LUT_EN defined:
  - The CORDIC is replaced by a 17-entry quarter-wave sine ROM indexed by i_deg[3:0] (and 16-i_deg[3:0] for cos), followed by the same FIX quadrant mapping.
  - Latency is fixed at 3 cycles for all modes.
  - Results are exact-rounded.
- Undefined: the CORDIC path above applies; no ROM is instantiated.

Test Plan:
- Reset, idle -> o_cos=16384, o_sin=0, o_busy=0, o_valid=0.
- newtask deg=0 mode=1 -> o_busy=1 in the newtask cycle; o_valid after 17 cycles; cos=16384+/-3, sin=0+/-3.
- newtask deg=6 mode=2 -> cos=13623+/-3, sin=9102+/-3; o_mode=2.
- deg=16 -> (0, 16384); deg=32 -> (-16384, 0); deg=48 -> (0, -16384); each within +/-3.
- mode=0 deg=20 -> valid after 2 cycles, cos=16384, sin=0, o_mode=0; a second newtask issued while busy is ignored.
- Assert i_rst_n low mid-ITER -> outputs return to reset values, no o_valid pulse; a subsequent task completes normally.
